// File: rtl/uart_tx_arb_if.sv
// Requester valid/ready/last bundle plus the parallel load port of the shared UART transmitter.
// The slave modport is the arbiter; the master modport is the client/transmitter side.
interface uart_tx_arb_if #(
  parameter int WD_SIZE = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]         req_vld_i;
  logic [NUM_REQ*WD_SIZE-1:0] req_data_i;
  logic [NUM_REQ-1:0]         req_last_i;
  logic [NUM_REQ-1:0]         req_rdy_o;
  logic [NUM_REQ-1:0]         gnt_o;
  logic [WD_SIZE-1:0]         tx_data_o;
  logic                       tx_vld_o;
  logic                       tx_rdy_i;
  logic                       timeout_o;

  modport master (
    output req_vld_i, req_data_i, req_last_i, tx_rdy_i,
    input  req_rdy_o, gnt_o, tx_data_o, tx_vld_o, timeout_o
  );

  modport slave (
    input  req_vld_i, req_data_i, req_last_i, tx_rdy_i,
    output req_rdy_o, gnt_o, tx_data_o, tx_vld_o, timeout_o
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locked arbiter that feeds one UART transmitter from NUM_REQ byte streams,
// with a one-entry output buffer and a watchdog that releases an owner stalled mid-packet.
module uart_tx_arb #(
  parameter int WD_SIZE = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         rstn,
  uart_tx_arb_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      own_q, own_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WD_SIZE-1:0] txd_q, txd_d;
  logic               txv_q, txv_d;
  logic [CW-1:0]      wd_q, wd_d;
  logic               to_q, to_d;

  logic [NUM_REQ-1:0] rdy;
  logic               out_free;
  logic               own_vld;
  logic               own_last;
  logic               xfer;
  logic [WD_SIZE-1:0] own_data;
  logic               pick_found;
  logic [IW-1:0]      pick_idx;

  // First valid requester after ptr, wrapping; a downward scan lets the nearest one win.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                          input logic [IW-1:0]      ptr);
    logic [IW-1:0] idx;
    rr_pick = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % NUM_REQ);
      if (vld[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    own_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) own_data = bus.req_data_i[k*WD_SIZE +: WD_SIZE];
    end
  end

  assign own_vld  = |(bus.req_vld_i & gnt_q);
  assign own_last = |(bus.req_last_i & gnt_q);
  assign out_free = !txv_q || bus.tx_rdy_i;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    gnt_d    = gnt_q;
    txd_d    = txd_q;
    txv_d    = txv_q;
    wd_d     = wd_q;
    to_d     = 1'b0;
    rdy      = '0;
    xfer     = 1'b0;
    {pick_found, pick_idx} = rr_pick(bus.req_vld_i, ptr_q);

    // The buffer drains in either state; a same-cycle fill below overrides this.
    if (bus.tx_rdy_i) txv_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          own_d   = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          wd_d    = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        rdy  = gnt_q & {NUM_REQ{out_free}};
        xfer = out_free && own_vld;
        if (xfer) begin
          txd_d = own_data;
          txv_d = 1'b1;
          wd_d  = '0;
          if (own_last) begin
            ptr_d   = own_q;
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (TIMEOUT > 0 && !own_vld) begin
          // Owner went quiet mid-packet; a stalled-but-valid owner never counts.
          if (wd_q == CW'(TIMEOUT - 1)) begin
            ptr_d   = own_q;
            gnt_d   = '0;
            wd_d    = '0;
            to_d    = 1'b1;
            state_d = IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      own_q   <= '0;
      gnt_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      gnt_q   <= gnt_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  assign bus.req_rdy_o = rdy;
  assign bus.gnt_o     = gnt_q;
  assign bus.tx_data_o = txd_q;
  assign bus.tx_vld_o  = txv_q;
  assign bus.timeout_o = to_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed timing scenarios plus randomized packet traffic checked
// against a packet-level round-robin model of the expected transmit byte stream.
module tb_uart_tx_arb;
  localparam int WD = 8;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.WD_SIZE(WD), .NUM_REQ(N)) bus ();

  uart_tx_arb #(.WD_SIZE(WD), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [8:0] src_q[N][$];   // bit 8 = last flag
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         gap[N];
  int         to_seen;
  int         inv_bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input bit v, input logic [7:0] d, input bit l);
    bus.req_vld_i[k]          = v;
    bus.req_data_i[k*WD +: WD] = d;
    bus.req_last_i[k]         = l;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.req_vld_i  = '0;
    bus.req_data_i = '0;
    bus.req_last_i = '0;
    bus.tx_rdy_i   = 1'b0;
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      gap[k] = 0;
    end
    got.delete();
    exp_q.delete();
    to_seen = 0;
    inv_bad = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Requesters present the head of their packet queue; the sink accepts with rdy_pct probability.
  task automatic run_engine(input int max_cyc, input int rdy_pct, input bit gaps, input int expect_n);
    int         cyc;
    bit         xf[N];
    logic [8:0] b;
    cyc = 0;
    while (cyc < max_cyc && got.size() < expect_n) begin
      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() > 0 && gap[k] == 0) drive(k, 1'b1, src_q[k][0][7:0], src_q[k][0][8]);
        else                                     drive(k, 1'b0, 8'h00, 1'b0);
      end
      bus.tx_rdy_i = ($urandom_range(99) < rdy_pct);
      #1;
      for (int k = 0; k < N; k++) xf[k] = bus.req_vld_i[k] & bus.req_rdy_o[k];
      if (bus.tx_vld_o && bus.tx_rdy_i) got.push_back(bus.tx_data_o);
      if (bus.timeout_o) to_seen++;
      if (($countones(bus.gnt_o) > 1) || ((bus.req_rdy_o & ~bus.gnt_o) != '0)) inv_bad++;
      tick();
      for (int k = 0; k < N; k++) begin
        if (xf[k]) begin
          b = src_q[k].pop_front();
          gap[k] = (gaps && !b[8] && src_q[k].size() > 0) ? int'($urandom_range(3)) : 0;
        end else if (gap[k] > 0) begin
          gap[k]--;
        end
      end
      cyc++;
    end
    for (int k = 0; k < N; k++) drive(k, 1'b0, 8'h00, 1'b0);
  endtask

  // Whole packets leave in round-robin order among requesters that still hold packets.
  task automatic build_expected(input int start_ptr);
    logic [8:0] m[N][$];
    logic [8:0] b;
    int p, k;
    bit found, any;
    for (int j = 0; j < N; j++) m[j] = src_q[j];
    p = start_ptr;
    exp_q.delete();
    any = 1'b1;
    while (any) begin
      found = 1'b0;
      for (int i = 1; i <= N && !found; i++) begin
        k = (p + i) % N;
        if (m[k].size() > 0) begin
          found = 1'b1;
          do begin
            b = m[k].pop_front();
            exp_q.push_back(b[7:0]);
          end while (!b[8] && m[k].size() > 0);
          p = k;
        end
      end
      any = found;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    bus.req_vld_i  = '0;
    bus.req_data_i = '0;
    bus.req_last_i = '0;
    bus.tx_rdy_i   = 1'b0;
    #1 rstn = 1'b0;
    #2;
    n_chk++; if (bus.gnt_o !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", bus.gnt_o); else n_pass++;
    n_chk++; if (bus.tx_vld_o !== 1'b0) $display("FAIL reset_tx_vld: got %b want 0", bus.tx_vld_o); else n_pass++;
    n_chk++; if (bus.tx_data_o !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.tx_data_o); else n_pass++;
    n_chk++; if (bus.timeout_o !== 1'b0) $display("FAIL reset_timeout: got %b want 0", bus.timeout_o); else n_pass++;
    n_chk++; if (bus.req_rdy_o !== 4'b0000) $display("FAIL reset_rdy: got %b want 0000", bus.req_rdy_o); else n_pass++;
    bus.req_vld_i = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (bus.gnt_o !== 4'b0000) $display("FAIL reset_held_gnt: got %b want 0000", bus.gnt_o); else n_pass++;
  endtask

  task automatic test_single_packet();
    do_reset();
    drive(2, 1'b1, 8'h41, 1'b0);
    bus.tx_rdy_i = 1'b1;
    #1;
    n_chk++; if (bus.req_rdy_o !== 4'b0000) $display("FAIL single_idle_rdy: got %b want 0000", bus.req_rdy_o); else n_pass++;
    tick();
    n_chk++; if (bus.gnt_o !== 4'b0100) $display("FAIL single_gnt_c1: got %b want 0100", bus.gnt_o); else n_pass++;
    n_chk++; if (bus.req_rdy_o !== 4'b0100) $display("FAIL single_rdy_c1: got %b want 0100", bus.req_rdy_o); else n_pass++;
    tick();
    drive(2, 1'b1, 8'h42, 1'b1);
    #1;
    n_chk++; if (!(bus.tx_vld_o === 1'b1 && bus.tx_data_o === 8'h41)) $display("FAIL single_byte0_c2: got vld=%b data=%h want vld=1 data=41", bus.tx_vld_o, bus.tx_data_o); else n_pass++;
    tick();
    drive(2, 1'b0, 8'h00, 1'b0);
    #1;
    n_chk++; if (!(bus.tx_vld_o === 1'b1 && bus.tx_data_o === 8'h42)) $display("FAIL single_byte1_c3: got vld=%b data=%h want vld=1 data=42", bus.tx_vld_o, bus.tx_data_o); else n_pass++;
    tick();
    n_chk++; if (!(bus.gnt_o === 4'b0000 && bus.tx_vld_o === 1'b0)) $display("FAIL single_done_c4: got gnt=%b vld=%b want gnt=0000 vld=0", bus.gnt_o, bus.tx_vld_o); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [7:0] rr_exp[4];
    rr_exp = '{8'hA0, 8'hA1, 8'hA3, 8'hB0};
    do_reset();
    src_q[0].push_back(9'h1A0);
    src_q[0].push_back(9'h1B0);
    src_q[1].push_back(9'h1A1);
    src_q[3].push_back(9'h1A3);
    run_engine(100, 100, 1'b0, 4);
    n_chk++; if (got.size() !== 4) $display("FAIL rr_count: got %0d bytes want 4", got.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_chk++; if (got[i] !== rr_exp[i]) $display("FAIL rr_byte%0d: got %h want %h", i, got[i], rr_exp[i]); else n_pass++;
    end
  endtask

  task automatic test_packet_lock();
    logic [7:0] lk_exp[4];
    lk_exp = '{8'hC0, 8'hC1, 8'hC2, 8'hD0};
    do_reset();
    src_q[0].push_back(9'h0C0);
    src_q[0].push_back(9'h0C1);
    src_q[0].push_back(9'h1C2);
    src_q[1].push_back(9'h1D0);
    run_engine(200, 50, 1'b0, 4);
    n_chk++; if (got.size() !== 4) $display("FAIL lock_count: got %0d bytes want 4", got.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_chk++; if (got[i] !== lk_exp[i]) $display("FAIL lock_byte%0d: got %h want %h", i, got[i], lk_exp[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int d_bad, r_bad, t_bad;
    logic [7:0] bp_exp[3];
    bp_exp = '{8'h51, 8'h52, 8'h53};
    do_reset();
    drive(2, 1'b1, 8'h51, 1'b0);
    bus.tx_rdy_i = 1'b1;
    tick();
    tick();
    drive(2, 1'b1, 8'h52, 1'b0);
    bus.tx_rdy_i = 1'b0;
    #1;
    d_bad = 0; r_bad = 0; t_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (!(bus.tx_vld_o === 1'b1 && bus.tx_data_o === 8'h51)) d_bad++;
      if (bus.req_rdy_o !== 4'b0000) r_bad++;
      if (bus.timeout_o !== 1'b0) t_bad++;
      tick();
    end
    n_chk++; if (d_bad !== 0) $display("FAIL bp_hold_data: %0d unstable cycles want 0", d_bad); else n_pass++;
    n_chk++; if (r_bad !== 0) $display("FAIL bp_rdy_low: %0d cycles with rdy want 0", r_bad); else n_pass++;
    n_chk++; if (t_bad !== 0) $display("FAIL bp_no_timeout: %0d pulses want 0", t_bad); else n_pass++;
    src_q[2].push_back(9'h052);
    src_q[2].push_back(9'h153);
    run_engine(100, 100, 1'b0, 3);
    n_chk++; if (got.size() !== 3) $display("FAIL bp_count: got %0d bytes want 3", got.size()); else n_pass++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_chk++; if (got[i] !== bp_exp[i]) $display("FAIL bp_byte%0d: got %h want %h", i, got[i], bp_exp[i]); else n_pass++;
    end
  endtask

  task automatic test_watchdog();
    int n;
    do_reset();
    drive(0, 1'b1, 8'hE0, 1'b0);
    drive(3, 1'b1, 8'hF3, 1'b1);
    bus.tx_rdy_i = 1'b1;
    tick();
    n_chk++; if (bus.gnt_o !== 4'b0001) $display("FAIL wd_first_gnt: got %b want 0001", bus.gnt_o); else n_pass++;
    tick();
    drive(0, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (bus.timeout_o !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    n_chk++; if (n !== TO) $display("FAIL wd_delay: timeout after %0d idle cycles want %0d", n, TO); else n_pass++;
    n_chk++; if (bus.gnt_o !== 4'b0000) $display("FAIL wd_release_gnt: got %b want 0000", bus.gnt_o); else n_pass++;
    tick();
    n_chk++; if (bus.gnt_o !== 4'b1000) $display("FAIL wd_next_gnt: got %b want 1000", bus.gnt_o); else n_pass++;
    n_chk++; if (bus.timeout_o !== 1'b0) $display("FAIL wd_pulse_width: got %b want 0", bus.timeout_o); else n_pass++;
    tick();
    drive(3, 1'b0, 8'h00, 1'b0);
    #1;
    n_chk++; if (!(bus.tx_vld_o === 1'b1 && bus.tx_data_o === 8'hF3)) $display("FAIL wd_next_byte: got vld=%b data=%h want vld=1 data=f3", bus.tx_vld_o, bus.tx_data_o); else n_pass++;
  endtask

  task automatic test_random();
    int npk, len, mism;
    logic [7:0] d;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int k = 0; k < N; k++) begin
        npk = $urandom_range(3);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(4, 1);
          for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            src_q[k].push_back({(i == len - 1), d});
          end
        end
      end
      build_expected(N - 1);
      run_engine(3000, 40 + 30 * r, 1'b1, exp_q.size());
      n_chk++; if (got.size() !== exp_q.size()) $display("FAIL rand%0d_count: got %0d bytes want %0d", r, got.size(), exp_q.size()); else n_pass++;
      mism = 0;
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) if (got[i] !== exp_q[i]) mism++;
      n_chk++; if (mism !== 0) $display("FAIL rand%0d_order: %0d bytes out of order want 0", r, mism); else n_pass++;
      n_chk++; if (to_seen !== 0) $display("FAIL rand%0d_timeout: %0d pulses want 0", r, to_seen); else n_pass++;
      n_chk++; if (inv_bad !== 0) $display("FAIL rand%0d_grant_shape: %0d bad cycles want 0", r, inv_bad); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive(0, 1'b1, 8'h61, 1'b0);
    bus.tx_rdy_i = 1'b0;
    tick();
    tick();
    drive(0, 1'b1, 8'h62, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    n_chk++; if (bus.tx_vld_o !== 1'b0) $display("FAIL rmid_tx_vld: got %b want 0", bus.tx_vld_o); else n_pass++;
    n_chk++; if (bus.gnt_o !== 4'b0000) $display("FAIL rmid_gnt: got %b want 0000", bus.gnt_o); else n_pass++;
    n_chk++; if (bus.req_rdy_o !== 4'b0000) $display("FAIL rmid_rdy: got %b want 0000", bus.req_rdy_o); else n_pass++;
    n_chk++; if (bus.tx_data_o !== 8'h00) $display("FAIL rmid_tx_data: got %h want 00", bus.tx_data_o); else n_pass++;
    drive(0, 1'b1, 8'h81, 1'b1);
    drive(1, 1'b1, 8'h71, 1'b1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    n_chk++; if (bus.gnt_o !== 4'b0001) $display("FAIL rmid_priority: got %b want 0001", bus.gnt_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_watchdog();
    test_random();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d of %0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
